// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - phase codes, phase type and width helpers for stage_seq
package stage_pkg;

    typedef enum logic [2:0] {
        PH_OPENING   = 3'd0,
        PH_BANNER    = 3'd1,
        PH_PLAY      = 3'd2,
        PH_GAME_OVER = 3'd3,
        PH_FINISH    = 3'd4
    } phase_t;

    // Width needed to hold stage numbers 0..n
    function automatic int stage_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width needed to hold life counts 0..n
    function automatic int life_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stage_timer.sv
// rtl/stage_timer.sv - loadable saturating down-counter with done flag
module stage_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Load on phase entry, otherwise count down and stick at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/stage_seq.sv
// rtl/stage_seq.sv - game stage sequencer: opening, banner, play, game over, finish
module stage_seq
    import stage_pkg::*;
#(
    parameter int NUM_STAGES    = 3,
    parameter int LIVES         = 3,
    parameter int BANNER_CYCLES = 4,
    parameter int END_CYCLES    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [stage_w(NUM_STAGES)-1:0]   sel_stage,
    input  logic                             stage_clear,
    input  logic                             player_hit,
    input  logic                             ack,
    input  logic                             abort,
    output logic [2:0]                       phase,
    output logic [stage_w(NUM_STAGES)-1:0]   cur_stage,
    output logic [life_w(LIVES)-1:0]         lives,
    output logic                             stage_start
);

    localparam int STAGE_W = stage_w(NUM_STAGES);
    localparam int LIFE_W  = life_w(LIVES);
    localparam int TMAX    = (BANNER_CYCLES > END_CYCLES) ? BANNER_CYCLES : END_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES);
    localparam logic [STAGE_W-1:0] ONE_STAGE  = STAGE_W'(1);
    localparam logic [LIFE_W-1:0]  FULL_LIVES = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0]  ONE_LIFE   = LIFE_W'(1);

    phase_t               phase_q, phase_d;
    logic [STAGE_W-1:0]   stage_d;
    logic [LIFE_W-1:0]    lives_d;
    logic                 start_d;
    logic                 t_load;
    logic [TIMER_W-1:0]   t_val;
    logic                 t_done;

    stage_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= PH_OPENING;
            cur_stage   <= '0;
            lives       <= '0;
            stage_start <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cur_stage   <= stage_d;
            lives       <= lives_d;
            stage_start <= start_d;
        end
    end

    // Next phase, stage, lives and timer reload on every phase entry
    always_comb begin
        phase_d = phase_q;
        stage_d = cur_stage;
        lives_d = lives;
        start_d = 1'b0;
        t_load  = 1'b0;
        t_val   = '0;

        if (abort) begin
            phase_d = PH_OPENING;
            stage_d = '0;
            lives_d = '0;
        end else begin
            case (phase_q)
                PH_OPENING: begin
                    if (start) begin
                        phase_d = PH_BANNER;
                        lives_d = FULL_LIVES;
                        if (sel_stage == '0 || sel_stage > LAST_STAGE) begin
                            stage_d = ONE_STAGE;
                        end else begin
                            stage_d = sel_stage;
                        end
                    end
                end
                PH_BANNER: begin
                    if (t_done) begin
                        phase_d = PH_PLAY;
                        start_d = 1'b1;
                    end
                end
                PH_PLAY: begin
                    // A clear outranks a hit arriving in the same cycle
                    if (stage_clear) begin
                        if (cur_stage < LAST_STAGE) begin
                            stage_d = cur_stage + ONE_STAGE;
                            phase_d = PH_BANNER;
                        end else begin
                            phase_d = PH_FINISH;
                        end
                    end else if (player_hit) begin
                        if (lives > ONE_LIFE) begin
                            lives_d = lives - ONE_LIFE;
                            phase_d = PH_BANNER;
                        end else begin
                            lives_d = '0;
                            phase_d = PH_GAME_OVER;
                        end
                    end
                end
                PH_GAME_OVER, PH_FINISH: begin
                    if (ack || t_done) begin
                        phase_d = PH_OPENING;
                        stage_d = '0;
                        lives_d = '0;
                    end
                end
                default: begin
                    phase_d = PH_OPENING;
                    stage_d = '0;
                    lives_d = '0;
                end
            endcase
        end

        if (abort || phase_d != phase_q) begin
            t_load = 1'b1;
            case (phase_d)
                PH_BANNER:              t_val = TIMER_W'(BANNER_CYCLES - 1);
                PH_GAME_OVER, PH_FINISH: t_val = TIMER_W'(END_CYCLES - 1);
                default:                t_val = '0;
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_stage_seq.sv
// tb/tb_stage_seq.sv - randomized and directed bench for stage_seq against a phase-level model
module tb_stage_seq;

    localparam int NS = 3;
    localparam int LV = 3;
    localparam int BC = 4;
    localparam int EC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel_stage = '0;
    logic       stage_clear = 1'b0;
    logic       player_hit = 1'b0;
    logic       ack = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] phase;
    logic [1:0] cur_stage;
    logic [1:0] lives;
    logic       stage_start;

    logic       w_start = 1'b0;
    logic [2:0] w_sel = '0;
    logic       w_abort = 1'b0;
    logic       tie0 = 1'b0;
    logic [2:0] w_phase;
    logic [2:0] w_stage;
    logic [1:0] w_lives;
    logic       w_ss;

    int checks = 0;
    int failures = 0;

    int m_phase, m_stage, m_lives, m_cnt, m_ss;

    stage_seq #(.NUM_STAGES(NS), .LIVES(LV), .BANNER_CYCLES(BC), .END_CYCLES(EC)) dut (
        .clk(clk), .reset(reset), .start(start), .sel_stage(sel_stage),
        .stage_clear(stage_clear), .player_hit(player_hit), .ack(ack), .abort(abort),
        .phase(phase), .cur_stage(cur_stage), .lives(lives), .stage_start(stage_start)
    );

    stage_seq #(.NUM_STAGES(5), .LIVES(3), .BANNER_CYCLES(4), .END_CYCLES(8)) dut_wide (
        .clk(clk), .reset(reset), .start(w_start), .sel_stage(w_sel),
        .stage_clear(tie0), .player_hit(tie0), .ack(tie0), .abort(w_abort),
        .phase(w_phase), .cur_stage(w_stage), .lives(w_lives), .stage_start(w_ss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_to_opening();
        m_phase = 0; m_stage = 0; m_lives = 0; m_cnt = 0;
    endtask

    // Phase-level rules: m_cnt counts cycles already spent in the current phase
    task automatic model_update(input logic s, input int sel, input logic sc,
                                input logic ph, input logic ak, input logic ab);
        m_ss = 0;
        if (ab) begin
            model_to_opening();
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1; m_lives = LV; m_cnt = 0;
                m_stage = (sel == 0 || sel > NS) ? 1 : sel;
            end
        end else if (m_phase == 1) begin
            if (m_cnt == BC - 1) begin
                m_phase = 2; m_ss = 1; m_cnt = 0;
            end else m_cnt++;
        end else if (m_phase == 2) begin
            if (sc) begin
                if (m_stage < NS) begin m_stage++; m_phase = 1; end
                else m_phase = 4;
                m_cnt = 0;
            end else if (ph) begin
                if (m_lives > 1) begin m_lives--; m_phase = 1; end
                else begin m_lives = 0; m_phase = 3; end
                m_cnt = 0;
            end
        end else begin
            if (ak || m_cnt == EC - 1) model_to_opening();
            else m_cnt++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".phase"}, 8'(phase), 8'(m_phase));
        chk({tag, ".stage"}, 8'(cur_stage), 8'(m_stage));
        chk({tag, ".lives"}, 8'(lives), 8'(m_lives));
        chk({tag, ".stage_start"}, 8'(stage_start), 8'(m_ss));
    endtask

    task automatic tick(input string tag, input logic s, input logic [1:0] sel, input logic sc,
                        input logic ph, input logic ak, input logic ab);
        start = s; sel_stage = sel; stage_clear = sc; player_hit = ph; ack = ak; abort = ab;
        @(posedge clk);
        model_update(s, int'(sel), sc, ph, ak, ab);
        #1;
        check_model(tag);
        start = 0; sel_stage = '0; stage_clear = 0; player_hit = 0; ack = 0; abort = 0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_play(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (m_phase == 2) break;
            tick(tag, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic wtick(input logic s, input logic [2:0] sel, input logic ab);
        w_start = s; w_sel = sel; w_abort = ab;
        @(posedge clk);
        model_update(0, 0, 0, 0, 0, 0);
        #1;
        w_start = 0; w_sel = '0; w_abort = 0;
    endtask

    initial begin
        model_to_opening();
        m_ss = 0;
        #1;
        chk("reset.phase", 8'(phase), 8'd0);
        chk("reset.stage", 8'(cur_stage), 8'd0);
        chk("reset.lives", 8'(lives), 8'd0);
        chk("reset.stage_start", 8'(stage_start), 8'd0);
        @(negedge clk);
        reset = 0;

        // Start with sel 0 on the first edge after reset
        tick("start0", 1, 0, 0, 0, 0, 0);
        chk("start0.phase", 8'(phase), 8'd1);
        chk("start0.stage", 8'(cur_stage), 8'd1);
        chk("start0.lives", 8'(lives), 8'd3);
        idle("banner", 3);
        chk("banner4.phase", 8'(phase), 8'd1);
        idle("toplay", 1);
        chk("play.phase", 8'(phase), 8'd2);
        chk("play.stage_start", 8'(stage_start), 8'd1);
        idle("play2", 1);
        chk("play2.stage_start", 8'(stage_start), 8'd0);

        // Clear and hit together: clear wins, lives kept
        tick("both", 0, 0, 1, 1, 0, 0);
        chk("both.phase", 8'(phase), 8'd1);
        chk("both.stage", 8'(cur_stage), 8'd2);
        chk("both.lives", 8'(lives), 8'd3);

        // Three hits in stage 2
        wait_play("wp1");
        tick("hit1", 0, 0, 0, 1, 0, 0);
        chk("hit1.lives", 8'(lives), 8'd2);
        wait_play("wp2");
        tick("hit2", 0, 0, 0, 1, 0, 0);
        chk("hit2.lives", 8'(lives), 8'd1);
        chk("hit2.stage", 8'(cur_stage), 8'd2);
        wait_play("wp3");
        tick("hit3", 0, 0, 0, 1, 0, 0);
        chk("hit3.phase", 8'(phase), 8'd3);
        chk("hit3.lives", 8'(lives), 8'd0);
        idle("go", 1);
        tick("ack", 0, 0, 0, 0, 1, 0);
        chk("ack.phase", 8'(phase), 8'd0);

        // Clear through all stages, then the finish timeout
        tick("start1", 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            wait_play("wpc");
            tick("clr", 0, 0, 1, 0, 0, 0);
        end
        chk("fin.phase", 8'(phase), 8'd4);
        chk("fin.stage", 8'(cur_stage), 8'd3);
        idle("fin", 7);
        chk("fin7.phase", 8'(phase), 8'd4);
        idle("fin8", 1);
        chk("fin8.phase", 8'(phase), 8'd0);
        chk("fin8.stage", 8'(cur_stage), 8'd0);

        // Abort mid-banner
        tick("start2", 1, 2, 0, 0, 0, 0);
        idle("b", 1);
        tick("abort", 0, 0, 0, 0, 0, 1);
        chk("abort.phase", 8'(phase), 8'd0);
        chk("abort.lives", 8'(lives), 8'd0);

        // Non-start pulses in OPENING
        tick("op_sc", 0, 0, 1, 0, 0, 0);
        tick("op_ph", 0, 0, 0, 1, 0, 0);
        tick("op_ack", 0, 0, 0, 0, 1, 0);
        chk("op.phase", 8'(phase), 8'd0);

        // Asynchronous reset mid-PLAY
        tick("start3", 1, 3, 0, 0, 0, 0);
        wait_play("wpr");
        #2 reset = 1;
        #1;
        chk("areset.phase", 8'(phase), 8'd0);
        chk("areset.stage", 8'(cur_stage), 8'd0);
        chk("areset.lives", 8'(lives), 8'd0);
        model_to_opening();
        m_ss = 0;
        @(negedge clk);
        reset = 0;

        // Randomized play
        for (int i = 0; i < 600; i++) begin
            tick("rnd",
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        // Out-of-range selection on a wider instance
        wtick(1, 3'd7, 0);
        chk("w7.phase", 8'(w_phase), 8'd1);
        chk("w7.stage", 8'(w_stage), 8'd1);
        chk("w7.lives", 8'(w_lives), 8'd3);
        wtick(0, 3'd0, 1);
        chk("wab.phase", 8'(w_phase), 8'd0);
        wtick(1, 3'd5, 0);
        chk("w5.stage", 8'(w_stage), 8'd5);
        wtick(0, 3'd0, 1);
        wtick(1, 3'd6, 0);
        chk("w6.stage", 8'(w_stage), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_seq.md
STAGE_SEQ -- requirements
Module: stage_seq

Interface
REQ-001 SHALL: parameter NUM_STAGES, default 3; number of playable stages, legal 1..15.
REQ-002 SHALL: parameter LIVES, default 3; lives granted at game start, legal 1..7.
REQ-003 SHALL: parameter BANNER_CYCLES, default 4; cycles the stage banner shows before play, at least 1.
REQ-004 SHALL: parameter END_CYCLES, default 8; cycles in GAME_OVER/FINISH before the automatic return to OPENING, at least 1.
REQ-005 SHALL: clk  input  1  single clock; all logic is rising-edge.
REQ-006 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL: start  input  1  one-cycle request to begin a game; honoured only in OPENING.
REQ-008 SHALL: sel_stage  input  STAGE_W  first stage to play; sampled with start. STAGE_W = clog2(NUM_STAGES+1).
REQ-009 SHALL: stage_clear  input  1  pulse: current stage has been cleared.
REQ-010 SHALL: player_hit  input  1  pulse: player has lost a life.
REQ-011 SHALL: ack  input  1  pulse: leave GAME_OVER/FINISH early.
REQ-012 SHALL: abort  input  1  pulse: return to OPENING from any phase.
REQ-013 SHALL: phase  output  3  current phase code.
REQ-014 SHALL: cur_stage  output  STAGE_W  active stage number, 1..NUM_STAGES; 0 in OPENING.
REQ-015 SHALL: lives  output  LIFE_W  remaining lives; LIFE_W = clog2(LIVES+1).
REQ-016 SHALL: stage_start  output  1  one-cycle pulse on the first PLAY cycle of each attempt.

Function
REQ-017 SHALL: phases are OPENING=0, BANNER=1, PLAY=2, GAME_OVER=3 and FINISH=4; any other code returns to OPENING on the next edge.
REQ-018 SHALL: all outputs are registered; every transition takes effect on the edge after the cause is sampled (1-cycle latency).
REQ-019 SHALL: in OPENING, start moves to BANNER with lives=LIVES and cur_stage=sel_stage, or cur_stage=1 when sel_stage is 0 or above NUM_STAGES.
REQ-020 SHALL: BANNER lasts exactly BANNER_CYCLES cycles (timer loaded with BANNER_CYCLES-1 on entry), then moves to PLAY with stage_start high for that first PLAY cycle only.
REQ-021 SHALL: in PLAY, stage_clear with cur_stage<NUM_STAGES increments cur_stage and moves to BANNER; with cur_stage==NUM_STAGES it moves to FINISH and cur_stage holds.
REQ-022 SHALL: in PLAY, player_hit with lives>1 decrements lives and moves to BANNER with cur_stage unchanged (retry); with lives==1 it sets lives=0 and moves to GAME_OVER.
REQ-023 SHALL: when stage_clear and player_hit arrive in the same PLAY cycle, stage_clear wins and lives are not decremented.
REQ-024 SHALL: stage_clear, player_hit and ack are ignored outside the phases that consume them; start is ignored outside OPENING.
REQ-025 SHALL: GAME_OVER and FINISH return to OPENING on ack or after END_CYCLES cycles, whichever comes first; on entry to OPENING, cur_stage=0 and lives=0.
REQ-026 SHALL: abort has top priority over every other input in every phase and moves to OPENING on the next edge; the timer is cleared.
REQ-027 SHALL: the shared timer is reloaded on every phase entry; it never wraps and saturates at 0.

Reset
REQ-028 SHALL: reset asserted forces phase=OPENING, cur_stage=0, lives=0, stage_start=0 and timer=0 immediately, regardless of the clock.
REQ-029 SHALL: on the first edge after reset deasserts, the block is in OPENING and accepts start on that edge.

Structure
REQ-030 SHALL: package stage_pkg holds the phase codes, the phase typedef, and the STAGE_W and LIFE_W width functions.
REQ-031 SHALL: one sub-module, stage_timer, provides the loadable saturating down-counter with a done flag; its width is sized from max(BANNER_CYCLES, END_CYCLES).

Verification (NUM_STAGES=3, LIVES=3, BANNER_CYCLES=4, END_CYCLES=8)
REQ-032 SHALL: start with sel_stage=0 -> BANNER for 4 cycles with cur_stage=1 and lives=3, then PLAY with a single stage_start pulse.
REQ-033 SHALL: stage_clear in PLAY of stages 1, 2 and 3 in turn -> stage 2 BANNER, stage 3 BANNER, then FINISH with cur_stage=3, and OPENING exactly 8 cycles later.
REQ-034 SHALL: three player_hit pulses in stage 2 -> lives 2 then 1 with a re-BANNER of stage 2 each time, then GAME_OVER with lives=0; ack 2 cycles later -> OPENING.
REQ-035 SHALL: stage_clear and player_hit together in stage 1 PLAY -> stage 2 BANNER with lives=3.
REQ-036 SHALL: abort in the middle of BANNER, and reset asserted mid-PLAY -> phase=0, cur_stage=0, lives=0 on the next edge for abort and immediately for reset.
REQ-037 SHALL: start with sel_stage=7, and stage_clear/start pulses in OPENING -> stage 1 is chosen; pulses other than start in OPENING leave the phase unchanged.
